dff_pipe: RTL
=============

Name: dff_pipe

Overview:
- Parametrised successor to the single-stage reset-value flip-flop.
- A DEPTH-stage registered pipeline, DATA_WIDTH wide, with a valid/ready handshake at every stage and a runtime-supplied reset value.
- Bubbles collapse, so a stalled output still lets upstream stages fill.
- Adds synchronous flush and an occupancy count.
- Used wherever datapath or state registers need retiming across several cycles under back-pressure.

Parameters:
- DATA_WIDTH, 8, width of the data path in bits (>=1).
- DEPTH, 2, number of register stages (>=1); elaboration error if 0.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stages; same effect as rst.
- reset_data  input  DATA_WIDTH  value loaded into every stage data register on rst or flush.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  DATA_WIDTH  input word.
- out_valid  output  1  stage DEPTH-1 holds a word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_WIDTH  last-stage data register; driven straight from the flop.
- count  output  CNT_WIDTH  number of valid stages, 0..DEPTH.

Behaviour:
- Per stage i: registers v[i] and d[i]. Stage 0 is fed from the input; stage DEPTH-1 drives the output.
- Advance enable for the last stage: adv[DEPTH-1] = out_ready | !v[DEPTH-1].
- Advance enable for other stages: adv[i] = adv[i+1] | !v[i], for i < DEPTH-1. This is a combinational ready chain.
- in_ready = adv[0]. It has no dependency on in_valid.
- Transfer rule: on posedge clk, when adv[i] is 1:
  - v[i] <= upstream valid (in_valid for i=0, v[i-1] otherwise).
  - d[i] <= upstream data.
- When adv[i] is 0, stage i holds both v[i] and d[i].
- d[i] loads only when upstream valid=1. When a bubble enters a stage, d[i] is unchanged and only v[i] clears.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1 when there are no stalls. Throughput is 1 word/cycle.
- Handshake rules:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on rst or flush.
- Reset and flush:
  - rst=1 or flush=1 at posedge clk: all v <= 0 and all d <= reset_data (value sampled that edge); count = 0.
  - Any concurrent input handshake is discarded.
  - rst has priority; flush and rst together behave as rst.
- Reset outputs: out_valid=0, out_data=reset_data, count=0. in_ready=1 combinationally, because every stage is empty.
- Reset mid-stream: all in-flight words are lost. The first accepted word after reset lands in stage 0 on the following edge.
- Full case: all DEPTH stages valid and out_ready=0 gives in_ready=0 and count=DEPTH.
- Full with out_ready=1: in_ready=1, and a simultaneous accept and emit keeps count=DEPTH.
- Empty case: count=0 and out_valid=0. in_valid is accepted immediately; there is no combinational bypass to the output.
- count: registered.
  - +1 on input transfer only.
  - -1 on output transfer only.
  - Unchanged when both or neither occur.
  - Never exceeds DEPTH and never underflows.
- DEPTH=1: degenerates to a single register with in_ready = out_ready | !v[0].

Decomposition:
- No shared package is required. CNT_WIDTH is derived locally.
- One natural sub-module, dff_pipe_stage: one data/valid register with the adv logic, reset_data load and flush. Instantiate it DEPTH times in a generate loop.
- The top level holds the ready chain and the occupancy counter.

Test Plan:
- Reset: rst=1 for 2 cycles with reset_data=8'hA5, DEPTH=3 -> out_valid=0, out_data=8'hA5, count=0, in_ready=1.
- Streaming: out_ready=1, send 8'h01..8'h0A back-to-back -> 8'h01 on out_data 2 cycles after acceptance, then one word per cycle in order; count steady at 3 during streaming.
- Back-pressure fill: out_ready=0, offer 5 words -> first 3 accepted, in_ready=0 and count=3; raise out_ready -> words exit in order 1,2,3, and words 4,5 are accepted as slots free.
- Bubble collapse: send 8'h11, idle 1 cycle, send 8'h22 with out_ready=0 -> both words packed into the last two stages, count=2, out_data=8'h11 held stable.
- Flush mid-stream: full pipeline, then pulse flush with reset_data=8'h00 while in_valid=1 -> next cycle count=0, out_valid=0, out_data=8'h00; the flushed-cycle input is not present later.
- Simultaneous accept/emit at full: count=3, in_valid=1, out_ready=1 for 4 cycles -> count stays 3 and output order is preserved.

Source files
------------

// File: rtl/dff_pipe_stage.sv
// -----------------------------------------------------------------------------
// dff_pipe_stage
//   One register stage of the dff_pipe retiming pipeline: a valid flag and a
//   data word, plus this stage's slice of the combinational ready chain.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears valid, loads reset_data)
//   flush       synchronous clear, identical effect to rst
//   reset_data  word loaded into the data register on rst/flush
//   up_valid    valid from the upstream stage (or pipeline input)
//   up_data     data from the upstream stage (or pipeline input)
//   adv_down    advance enable of the downstream stage (out_ready for the last)
//   adv         this stage's advance enable: it may take a new word this edge
//   valid       registered valid flag
//   data        registered data word
// -----------------------------------------------------------------------------
module dff_pipe_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] reset_data,
   input  logic                  up_valid,
   input  logic [DATA_WIDTH-1:0] up_data,
   input  logic                  adv_down,
   output logic                  adv,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data
);

   logic                  valid_reg;
   logic [DATA_WIDTH-1:0] data_reg;

   // An empty stage can always take a word; a full one only if its content
   // moves on. This is what lets bubbles collapse under back-pressure.
   assign adv   = adv_down | ~valid_reg;
   assign valid = valid_reg;
   assign data  = data_reg;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_reg <= 1'b0;
         data_reg  <= reset_data;
      end else if (adv) begin
         valid_reg <= up_valid;
         // A bubble only clears the valid flag; the data word is kept so the
         // output register never shows garbage between words.
         if (up_valid) begin
            data_reg <= up_data;
         end
      end
   end

endmodule

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
//   DEPTH-stage registered pipeline with a valid/ready handshake at every
//   stage, runtime reset value, synchronous flush and an occupancy count.
//   Bubbles collapse: a stalled output still lets upstream stages fill.
//   Latency without stalls is DEPTH-1 edges after acceptance; throughput is
//   one word per cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   flush       synchronous clear of all stages (rst wins if both asserted)
//   reset_data  word loaded into every stage on rst/flush
//   in_valid    upstream offers in_data
//   in_ready    pipeline accepts in_data this cycle (independent of in_valid)
//   in_data     input word
//   out_valid   last stage holds a word
//   out_ready   downstream accepts out_data this cycle
//   out_data    last-stage data register, straight from the flop
//   count       number of valid stages, 0..DEPTH (registered)
// -----------------------------------------------------------------------------
module dff_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] reset_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  count
);

   if (DEPTH < 1) begin : g_bad_depth
      $error("dff_pipe: DEPTH must be at least 1");
   end

   // Stage 0 is fed from the input, stage DEPTH-1 drives the output. Each
   // stage's adv depends on the stage after it, forming the ready chain.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic                  stage_adv;
      logic                  adv_down;
      logic                  up_valid;
      logic [DATA_WIDTH-1:0] up_data;
      logic                  stage_valid;
      logic [DATA_WIDTH-1:0] stage_data;

      if (gi == DEPTH - 1) begin : g_last
         assign adv_down = out_ready;
      end else begin : g_mid
         assign adv_down = g_stage[gi+1].stage_adv;
      end

      if (gi == 0) begin : g_first
         assign up_valid = in_valid;
         assign up_data  = in_data;
      end else begin : g_follow
         assign up_valid = g_stage[gi-1].stage_valid;
         assign up_data  = g_stage[gi-1].stage_data;
      end

      dff_pipe_stage #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .reset_data (reset_data),
         .up_valid   (up_valid),
         .up_data    (up_data),
         .adv_down   (adv_down),
         .adv        (stage_adv),
         .valid      (stage_valid),
         .data       (stage_data)
      );
   end

   assign in_ready  = g_stage[0].stage_adv;
   assign out_valid = g_stage[DEPTH-1].stage_valid;
   assign out_data  = g_stage[DEPTH-1].stage_data;

   // Occupancy counter: tracks handshakes rather than summing valid flags.
   logic                 in_xfer;
   logic                 out_xfer;
   logic [CNT_WIDTH-1:0] count_reg;
   logic [CNT_WIDTH-1:0] count_next;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      count_next = count_reg;
      if (in_xfer && !out_xfer) begin
         count_next = count_reg + 1'b1;
      end else if (out_xfer && !in_xfer) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule
